// File: rtl/decode_scoreboard.sv
// Decode-stage register scoreboard: tracks in-flight destination registers with a latency
// countdown, detects RAW/WAW hazards, and gates issue into the pipeline.
module decode_scoreboard #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned LAT_W = 3,
   localparam int unsigned RW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_dec_valid,
   input  logic [RW-1:0]    in_rs1,
   input  logic [RW-1:0]    in_rs2,
   input  logic             in_use_rs1,
   input  logic             in_use_rs2,
   input  logic [RW-1:0]    in_rd,
   input  logic             in_writes_rd,
   input  logic [LAT_W-1:0] in_latency,
   input  logic             in_wb_valid,
   input  logic [RW-1:0]    in_wb_rd,
   input  logic             in_flush,
   output logic             out_stall,
   output logic             out_issue,
   output logic [NREGS-1:0] out_busy,
   output logic [XLEN-1:0]  out_stall_cycles
);

   localparam logic [LAT_W-1:0] LatMax = '1;
   localparam logic [LAT_W-1:0] CntOne = LAT_W'(1);
   localparam logic [XLEN-1:0]  StallMax = '1;
   localparam logic [XLEN-1:0]  StallOne = XLEN'(1);

   logic [NREGS-1:0]            pend_q, pend_d, pend_eff;
   logic [NREGS-1:0][LAT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]             stall_cnt_q, stall_cnt_d;

   logic raw1, raw2, waw, hazard, active, set_rd;

   // A writeback landing this cycle resolves the hazard without waiting for the register update.
   always_comb begin
      pend_eff = '0;
      for (int unsigned i = 1; i < NREGS; i++) begin
         pend_eff[i] = pend_q[i] && !(in_wb_valid && (in_wb_rd == RW'(i)));
      end
   end

   // cnt == 0 means the value is forwardable, so only WAW still blocks on it.
   always_comb begin
      raw1   = in_use_rs1 && (in_rs1 != '0) && pend_eff[in_rs1] && (cnt_q[in_rs1] != '0);
      raw2   = in_use_rs2 && (in_rs2 != '0) && pend_eff[in_rs2] && (cnt_q[in_rs2] != '0);
      waw    = in_writes_rd && (in_rd != '0) && pend_eff[in_rd];
      hazard = raw1 || raw2 || waw;
      active = in_dec_valid && !in_flush;
      out_stall = active && hazard;
      out_issue = active && !hazard;
      set_rd    = out_issue && in_writes_rd && (in_rd != '0);
   end

   always_comb begin
      pend_d = pend_q;
      cnt_d  = cnt_q;
      for (int unsigned i = 1; i < NREGS; i++) begin
         if (pend_q[i] && (cnt_q[i] != '0) && (cnt_q[i] != LatMax)) begin
            cnt_d[i] = cnt_q[i] - CntOne;
         end
      end
      if (in_wb_valid && (in_wb_rd != '0)) begin
         pend_d[in_wb_rd] = 1'b0;
         cnt_d[in_wb_rd]  = '0;
      end
      // Issue is applied last so it overrides a writeback to the same register.
      if (set_rd) begin
         pend_d[in_rd] = 1'b1;
         cnt_d[in_rd]  = in_latency;
      end
      pend_d[0] = 1'b0;
      cnt_d[0]  = '0;
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_stall && (stall_cnt_q != StallMax)) begin
         stall_cnt_d = stall_cnt_q + StallOne;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q      <= '0;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         pend_q      <= pend_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_busy         = pend_q;
   assign out_stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Self-checking bench for decode_scoreboard: directed hazard scenarios plus randomized traffic
// against a per-register table model.
module tb_decode_scoreboard;

   localparam int XLEN  = 4;
   localparam int NREGS = 32;
   localparam int LAT_W = 3;
   localparam int RW    = 5;
   localparam int LMAX  = 7;
   localparam int SMAX  = 15;

   logic             clk = 1'b0;
   logic             reset;
   logic             dec_valid, use_rs1, use_rs2, writes_rd, wb_valid, flush;
   logic [RW-1:0]    rs1, rs2, rd, wb_rd;
   logic [LAT_W-1:0] lat;
   logic             stall, issue;
   logic [NREGS-1:0] busy;
   logic [XLEN-1:0]  stall_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: one entry per architectural register plus the stall tally.
   bit m_pend[NREGS];
   int m_cnt[NREGS];
   int m_stall_cnt;

   always #5 clk = ~clk;

   decode_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .LAT_W(LAT_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .in_dec_valid     (dec_valid),
      .in_rs1           (rs1),
      .in_rs2           (rs2),
      .in_use_rs1       (use_rs1),
      .in_use_rs2       (use_rs2),
      .in_rd            (rd),
      .in_writes_rd     (writes_rd),
      .in_latency       (lat),
      .in_wb_valid      (wb_valid),
      .in_wb_rd         (wb_rd),
      .in_flush         (flush),
      .out_stall        (stall),
      .out_issue        (issue),
      .out_busy         (busy),
      .out_stall_cycles (stall_cycles)
   );

   function automatic void model_clear();
      for (int r = 0; r < NREGS; r++) begin
         m_pend[r] = 0;
         m_cnt[r]  = 0;
      end
      m_stall_cnt = 0;
   endfunction

   function automatic bit wb_hits(int r);
      return wb_valid && (int'(wb_rd) == r);
   endfunction

   function automatic bit read_blocked(bit used, int r);
      return used && r != 0 && m_pend[r] && !wb_hits(r) && m_cnt[r] > 0;
   endfunction

   function automatic bit exp_stall();
      bit haz;
      if (!dec_valid || flush) return 0;
      haz = read_blocked(use_rs1, int'(rs1)) || read_blocked(use_rs2, int'(rs2));
      if (writes_rd && rd != 0 && m_pend[rd] && !wb_hits(int'(rd))) haz = 1;
      return haz;
   endfunction

   function automatic bit exp_issue();
      return dec_valid && !flush && !exp_stall();
   endfunction

   function automatic logic [NREGS-1:0] exp_busy();
      logic [NREGS-1:0] v;
      for (int r = 0; r < NREGS; r++) v[r] = m_pend[r];
      return v;
   endfunction

   // Advance the model by one clock using the inputs currently driven, then step the clock.
   task automatic tick();
      bit st, is;
      st = exp_stall();
      is = exp_issue();
      for (int r = 1; r < NREGS; r++) begin
         if (is && writes_rd && int'(rd) == r) begin
            m_pend[r] = 1;
            m_cnt[r]  = int'(lat);
         end else if (wb_hits(r)) begin
            m_pend[r] = 0;
            m_cnt[r]  = 0;
         end else if (m_pend[r] && m_cnt[r] > 0 && m_cnt[r] < LMAX) begin
            m_cnt[r] = m_cnt[r] - 1;
         end
      end
      if (st && m_stall_cnt < SMAX) m_stall_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic set_dec(bit v, bit u1, int r1, bit u2, int r2, bit w, int d, int l);
      dec_valid = v;
      use_rs1   = u1;
      rs1       = RW'(r1);
      use_rs2   = u2;
      rs2       = RW'(r2);
      writes_rd = w;
      rd        = RW'(d);
      lat       = LAT_W'(l);
      flush     = 0;
   endtask

   task automatic set_wb(bit v, int r);
      wb_valid = v;
      wb_rd    = RW'(r);
   endtask

   task automatic do_reset();
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      set_wb(0, 0);
      reset = 1;
      model_clear();
      @(posedge clk);
      #1;
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      model_clear();
      set_dec(1, 1, 3, 1, 4, 1, 3, 2);
      set_wb(0, 0);
      #1;
      n_checks++;
      if (busy !== '0) begin
         n_fail++; $display("FAIL reset_busy got %h want 0", busy);
      end
      n_checks++;
      if (stall_cycles !== '0) begin
         n_fail++; $display("FAIL reset_stall_cycles got %0d want 0", stall_cycles);
      end
      n_checks++;
      if (stall !== 1'b0 || issue !== 1'b1) begin
         n_fail++; $display("FAIL reset_issue got stall=%b issue=%b want stall=0 issue=1", stall, issue);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (busy !== '0) begin
         n_fail++; $display("FAIL reset_hold_busy got %h want 0", busy);
      end
      reset = 0;
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic test_raw_latency();
      set_dec(1, 0, 0, 0, 0, 1, 5, 2);
      #1;
      n_checks++;
      if (issue !== 1'b1 || stall !== 1'b0) begin
         n_fail++; $display("FAIL raw_first_issue got stall=%b issue=%b want 0/1", stall, issue);
      end
      tick();
      set_dec(1, 1, 5, 0, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         #1;
         n_checks++;
         if (stall !== 1'b1 || issue !== 1'b0 || busy[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_stall%0d got stall=%b issue=%b busy5=%b want 1/0/1", k, stall, issue, busy[5]);
         end
         tick();
      end
      #1;
      n_checks++;
      if (stall !== 1'b0 || issue !== 1'b1) begin
         n_fail++; $display("FAIL raw_release got stall=%b issue=%b want 0/1", stall, issue);
      end
      tick();
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      set_wb(1, 5);
      #1;
      n_checks++;
      if (busy[5] !== 1'b1) begin
         n_fail++; $display("FAIL raw_busy_before_wb got %b want 1", busy[5]);
      end
      tick();
      set_wb(0, 0);
      #1;
      n_checks++;
      if (busy[5] !== 1'b0) begin
         n_fail++; $display("FAIL raw_busy_after_wb got %b want 0", busy[5]);
      end
   endtask

   task automatic test_load_wb();
      set_dec(1, 0, 0, 0, 0, 1, 7, LMAX);
      #1;
      tick();
      set_dec(1, 0, 0, 1, 7, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         #1;
         n_checks++;
         if (stall !== 1'b1 || issue !== 1'b0) begin
            n_fail++; $display("FAIL load_stall%0d got stall=%b issue=%b want 1/0", k, stall, issue);
         end
         tick();
      end
      set_wb(1, 7);
      #1;
      n_checks++;
      if (stall !== 1'b0 || issue !== 1'b1) begin
         n_fail++; $display("FAIL load_wb_issue got stall=%b issue=%b want 0/1", stall, issue);
      end
      tick();
      set_wb(0, 0);
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      n_checks++;
      if (busy[7] !== 1'b0) begin
         n_fail++; $display("FAIL load_busy_clear got %b want 0", busy[7]);
      end
   endtask

   task automatic test_waw_forward();
      set_dec(1, 0, 0, 0, 0, 1, 3, 1);
      #1;
      tick();
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      tick();
      set_dec(1, 1, 3, 0, 0, 0, 0, 0);
      #1;
      n_checks++;
      if (stall !== 1'b0 || busy[3] !== 1'b1) begin
         n_fail++; $display("FAIL fwd_no_raw got stall=%b busy3=%b want 0/1", stall, busy[3]);
      end
      tick();
      set_dec(1, 0, 0, 0, 0, 1, 3, 4);
      #1;
      n_checks++;
      if (stall !== 1'b1 || issue !== 1'b0) begin
         n_fail++; $display("FAIL waw_stall got stall=%b issue=%b want 1/0", stall, issue);
      end
      tick();
      set_wb(1, 3);
      #1;
      n_checks++;
      if (stall !== 1'b0 || issue !== 1'b1) begin
         n_fail++; $display("FAIL waw_wb_issue got stall=%b issue=%b want 0/1", stall, issue);
      end
      tick();
      set_wb(0, 0);
      set_dec(1, 1, 3, 0, 0, 0, 0, 0);
      #1;
      n_checks++;
      if (busy[3] !== 1'b1 || stall !== 1'b1) begin
         n_fail++; $display("FAIL waw_new_cnt got busy3=%b stall=%b want 1/1", busy[3], stall);
      end
      tick();
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      set_wb(1, 3);
      #1;
      tick();
      set_wb(0, 0);
   endtask

   task automatic test_reg_zero();
      set_dec(1, 1, 0, 1, 0, 1, 0, 5);
      for (int k = 0; k < 2; k++) begin
         #1;
         n_checks++;
         if (stall !== 1'b0 || issue !== 1'b1 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg%0d got stall=%b issue=%b busy0=%b want 0/1/0", k, stall, issue, busy[0]);
         end
         tick();
      end
   endtask

   task automatic test_flush();
      set_dec(1, 0, 0, 0, 0, 1, 4, 3);
      #1;
      tick();
      set_dec(1, 1, 4, 0, 0, 0, 0, 0);
      flush = 1;
      #1;
      n_checks++;
      if (stall !== 1'b0 || issue !== 1'b0) begin
         n_fail++; $display("FAIL flush_suppress got stall=%b issue=%b want 0/0", stall, issue);
      end
      tick();
      flush = 0;
      for (int k = 0; k < 2; k++) begin
         #1;
         n_checks++;
         if (stall !== 1'b1 || busy[4] !== 1'b1) begin
            n_fail++; $display("FAIL flush_countdown%0d got stall=%b busy4=%b want 1/1", k, stall, busy[4]);
         end
         tick();
      end
      #1;
      n_checks++;
      if (issue !== 1'b1) begin
         n_fail++; $display("FAIL flush_release got issue=%b want 1", issue);
      end
      tick();
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      set_wb(1, 4);
      #1;
      tick();
      set_wb(0, 0);
   endtask

   task automatic test_stall_count();
      do_reset();
      set_dec(1, 0, 0, 0, 0, 1, 9, LMAX);
      #1;
      tick();
      set_dec(1, 1, 9, 0, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++) begin
         #1;
         tick();
      end
      #1;
      n_checks++;
      if (int'(stall_cycles) !== 10) begin
         n_fail++; $display("FAIL stall_cnt_10 got %0d want 10", stall_cycles);
      end
      #1;
      reset = 1;
      model_clear();
      #1;
      n_checks++;
      if (stall_cycles !== '0 || busy !== '0) begin
         n_fail++; $display("FAIL midreset got cnt=%0d busy=%h want 0/0", stall_cycles, busy);
      end
      n_checks++;
      if (stall !== 1'b0 || issue !== 1'b1) begin
         n_fail++; $display("FAIL midreset_issue got stall=%b issue=%b want 0/1", stall, issue);
      end
      @(posedge clk);
      #1;
      reset = 0;
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      set_wb(1, 9);
      #1;
      tick();
      set_wb(0, 0);
      #1;
      n_checks++;
      if (busy !== '0) begin
         n_fail++; $display("FAIL stale_wb got busy=%h want 0", busy);
      end
      set_dec(1, 0, 0, 0, 0, 1, 9, LMAX);
      tick();
      set_dec(1, 1, 9, 0, 0, 0, 0, 0);
      for (int k = 0; k < 20; k++) begin
         #1;
         tick();
      end
      #1;
      n_checks++;
      if (int'(stall_cycles) !== SMAX || stall !== 1'b1) begin
         n_fail++; $display("FAIL stall_cnt_sat got %0d stall=%b want %0d/1", stall_cycles, stall, SMAX);
      end
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      set_wb(1, 9);
      tick();
      set_wb(0, 0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         if (k % 60 == 0) do_reset();
         set_dec($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 7), $urandom_range(0, LMAX));
         flush = ($urandom_range(0, 9) == 0);
         set_wb($urandom_range(0, 2) == 0, $urandom_range(0, 7));
         #1;
         n_checks++;
         if (stall !== exp_stall() || issue !== exp_issue()) begin
            n_fail++;
            $display("FAIL rand_ctl cyc=%0d got stall=%b issue=%b want %b/%b",
                     k, stall, issue, exp_stall(), exp_issue());
         end
         n_checks++;
         if (busy !== exp_busy()) begin
            n_fail++; $display("FAIL rand_busy cyc=%0d got %h want %h", k, busy, exp_busy());
         end
         n_checks++;
         if (int'(stall_cycles) !== m_stall_cnt) begin
            n_fail++; $display("FAIL rand_stall_cnt cyc=%0d got %0d want %0d", k, stall_cycles, m_stall_cnt);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_raw_latency();
      test_load_wb();
      test_waw_forward();
      test_reg_zero();
      test_flush();
      test_stall_count();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_scoreboard.md
DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

Interface
REQ-001 Parameter XLEN, default 32: datapath width; carried only into the stall counter width.
REQ-002 Parameter NREGS, default 32: architectural register count; power of two, 2..32; index width RW = log2(NREGS).
REQ-003 Parameter LAT_W, default 3: latency field width; LAT_MAX = 2^LAT_W - 1.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 in_dec_valid  in  1  decode holds a valid instruction.
REQ-007 in_rs1 / in_rs2  in  RW each  source register indices.
REQ-008 in_use_rs1 / in_use_rs2  in  1 each  the instruction reads that source.
REQ-009 in_rd  in  RW  destination index; in_writes_rd  in  1  the instruction writes rd.
REQ-010 in_latency  in  LAT_W  cycles until the result is forwardable; LAT_MAX means unknown (load), resolved only by writeback.
REQ-011 in_wb_valid  in  1  writeback this cycle; in_wb_rd  in  RW  writeback register.
REQ-012 in_flush  in  1  squash the instruction in decode this cycle.
REQ-013 out_stall  out  1  decode is blocked by a hazard (drives pc_write_disable / IFID_write_disable and the control-bubble select).
REQ-014 out_issue  out  1  the instruction leaves decode this cycle.
REQ-015 out_busy  out  NREGS  per-register pending bits, bit i = register i.
REQ-016 out_stall_cycles  out  XLEN  saturating count of stalled cycles.

Function
REQ-017 Each register i>0 SHALL hold pending[i] (1 bit) and cnt[i] (LAT_W bits); register 0 SHALL never be pending, and rd=0 SHALL never be tracked.
REQ-018 Effective pending pend_eff[i] SHALL be pending[i] AND NOT (in_wb_valid AND in_wb_rd==i): a same-cycle writeback resolves the hazard combinationally.
REQ-019 RAW hazard: a used source s SHALL be hazardous iff s!=0, pend_eff[s]=1 and cnt[s]!=0.
REQ-020 WAW hazard: SHALL exist iff in_writes_rd=1, in_rd!=0 and pend_eff[in_rd]=1.
REQ-021 out_stall SHALL be in_dec_valid AND NOT in_flush AND (any RAW or WAW hazard).
REQ-022 out_issue SHALL be in_dec_valid AND NOT in_flush AND NOT out_stall.
REQ-023 On out_issue with in_writes_rd=1 and in_rd!=0: pending[in_rd] <= 1 and cnt[in_rd] <= in_latency.
REQ-024 Writeback (in_wb_valid, in_wb_rd!=0) SHALL clear pending[in_wb_rd] and cnt[in_wb_rd]; a simultaneous issue to the same register SHALL win (set takes priority).
REQ-025 Each cycle, every other pending register with 0 < cnt < LAT_MAX SHALL decrement cnt by 1; cnt=0 holds (forwardable, awaiting writeback); cnt=LAT_MAX never decrements.
REQ-026 A register with pending=1 and cnt=0 SHALL not cause RAW stalls (forwarding covers it) but SHALL still cause WAW stalls.
REQ-027 in_flush SHALL not alter scoreboard state for instructions already issued; it only suppresses issue and stall in the current cycle.
REQ-028 out_stall_cycles SHALL increment by 1 each cycle out_stall=1 and saturate at 2^XLEN-1 without wrapping.
REQ-029 out_busy[i] SHALL reflect registered pending[i] (not pend_eff).
REQ-030 Hazard evaluation SHALL be purely combinational from current inputs and registered state; issue-to-scoreboard-update latency SHALL be one cycle.

Reset
REQ-031 On reset assertion, all pending, cnt and out_stall_cycles SHALL clear asynchronously; out_busy=0 immediately.
REQ-032 While reset is high, out_stall and out_issue SHALL follow REQ-021/022 with an empty scoreboard (no hazards).
REQ-033 Reset mid-operation SHALL discard all outstanding entries; later writebacks to those registers SHALL be harmless no-ops.

Verification
REQ-034 Issue rd=5, lat=2; next cycle decode uses rs1=5 -> out_stall=1 for 2 cycles, issue on 3rd cycle; out_busy[5]=1 until wb.
REQ-035 Issue rd=7, lat=LAT_MAX (load); decode uses rs2=7 -> stall until in_wb_valid with in_wb_rd=7; issue that same cycle; out_busy[7]=0 next cycle.
REQ-036 pending[3]=1, cnt=0; new instruction writes rd=3 -> out_stall=1 (WAW); wb_rd=3 same cycle -> out_issue=1, out_busy[3] stays 1 with new cnt.
REQ-037 Instruction using rs1=0, writing rd=0 -> never stalls, out_busy[0] stays 0.
REQ-038 Hazard present with in_flush=1 -> out_stall=0, out_issue=0, state unchanged except normal countdown.
REQ-039 Stall for 10 cycles, assert reset mid-stall -> out_stall_cycles=0, out_busy=0 immediately; with XLEN=4, 20 stall cycles -> counter holds 15.
